// File: rtl/ula_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ula_issue_ctrl
//   Initiator side of the ALU operand/opcode interface. Requests from the
//   control path are queued in a small FIFO. Ops are issued one at a time to
//   a purely combinational ALU. The operands and opcode are held stable for
//   SETTLE_CYCLES cycles, then the result and compare flags are captured. The
//   block derives its own error code and returns a tagged response.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     request handshake (ready = queue not full)
//   req_opcode/a/b/tag  request payload
//   alu_operand_a/b     operands driven into the ALU
//   alu_opcode          opcode driven into the ALU
//   alu_result          ALU result (combinational from the alu_* outputs)
//   alu_compare         ALU compare flags (00 eq, 01 a>b, 10 a<b)
//   rsp_valid/ready     response handshake
//   rsp_result          captured result (0 on any error)
//   rsp_cmp             compare flags for CMP; 11 for any other opcode
//   rsp_err             00 ok, 01 divide by zero, 10 illegal opcode
//   rsp_tag             tag of the request this response belongs to
//   busy                an op is in flight or the queue holds requests
// ---------------------------------------------------------------------------
module ula_issue_ctrl #(
  parameter int DATA_W        = 32,
  parameter int TAG_W         = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [1:0]        alu_compare,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [1:0]        rsp_cmp,
  output logic [1:0]        rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int ENTRY_W = 4 + 2 * DATA_W + TAG_W;

  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] CMP_NONE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
  } state_t;

  // Opcodes ADD(3) through NOT(12) form one contiguous legal range.
  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'd3) && (op <= 4'd12);
  endfunction

  // -------------------------------------------------------------------------
  // Request queue
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;

  logic [ENTRY_W-1:0] head_entry;
  logic [3:0]         head_op;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [TAG_W-1:0]   head_tag;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign req_ready  = !fifo_full;
  assign push       = req_valid && req_ready;

  // The head is read combinationally so a pop can load the ALU registers on
  // the same edge, which keeps back-to-back issue free of bubbles.
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign {head_op, head_a, head_b, head_tag} = head_entry;

  // Storage holds data only; validity is tracked by count/pointers, so the
  // array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_opcode, req_a, req_b, req_tag};
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Issue / capture / response FSM
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [SET_W-1:0]  settle_reg, settle_next;
  logic [DATA_W-1:0] alu_a_reg, alu_a_next;
  logic [DATA_W-1:0] alu_b_reg, alu_b_next;
  logic [3:0]        alu_op_reg, alu_op_next;
  logic [DATA_W-1:0] rsp_result_reg, rsp_result_next;
  logic [1:0]        rsp_cmp_reg, rsp_cmp_next;
  logic [1:0]        rsp_err_reg, rsp_err_next;
  logic [TAG_W-1:0]  rsp_tag_reg, rsp_tag_next;
  logic              load;

  always_comb begin
    state_next      = state_reg;
    settle_next     = settle_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    alu_op_next     = alu_op_reg;
    rsp_result_next = rsp_result_reg;
    rsp_cmp_next    = rsp_cmp_reg;
    rsp_err_next    = rsp_err_reg;
    rsp_tag_next    = rsp_tag_reg;
    load            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        load = !fifo_empty;
      end

      ST_DRIVE: begin
        if (settle_reg != '0) begin
          settle_next = settle_reg - SET_W'(1);
        end else begin
          // ALU inputs have been stable long enough: sample its outputs.
          rsp_result_next = alu_result;
          rsp_cmp_next    = (alu_op_reg == OP_CMP) ? alu_compare : CMP_NONE;
          rsp_err_next    = ERR_OK;
          // Divide-by-zero is judged from our own held operand; whatever the
          // ALU produced in that case is discarded.
          if ((alu_op_reg == OP_DIV) && (alu_b_reg == '0)) begin
            rsp_result_next = '0;
            rsp_err_next    = ERR_DIV0;
          end
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_next  = ST_IDLE;
            alu_a_next  = '0;
            alu_b_next  = '0;
            alu_op_next = '0;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Shared pop-and-issue path used from IDLE and from a RESP handshake.
    if (load) begin
      rsp_tag_next = head_tag;
      if (is_legal(head_op)) begin
        alu_a_next  = head_a;
        alu_b_next  = head_b;
        alu_op_next = head_op;
        settle_next = SET_W'(SETTLE_CYCLES - 1);
        state_next  = ST_DRIVE;
      end else begin
        // Illegal opcodes never reach the ALU; respond straight away.
        alu_a_next      = '0;
        alu_b_next      = '0;
        alu_op_next     = '0;
        rsp_result_next = '0;
        rsp_err_next    = ERR_ILLEGAL;
        rsp_cmp_next    = CMP_NONE;
        state_next      = ST_RESP;
      end
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      settle_reg     <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_cmp_reg    <= CMP_NONE;
      rsp_err_reg    <= ERR_OK;
      rsp_tag_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      settle_reg     <= settle_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      alu_op_reg     <= alu_op_next;
      rsp_result_reg <= rsp_result_next;
      rsp_cmp_reg    <= rsp_cmp_next;
      rsp_err_reg    <= rsp_err_next;
      rsp_tag_reg    <= rsp_tag_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign alu_operand_a = alu_a_reg;
  assign alu_operand_b = alu_b_reg;
  assign alu_opcode    = alu_op_reg;
  assign rsp_valid     = (state_reg == ST_RESP);
  assign rsp_result    = rsp_result_reg;
  assign rsp_cmp       = rsp_cmp_reg;
  assign rsp_err       = rsp_err_reg;
  assign rsp_tag       = rsp_tag_reg;
  assign busy          = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ula_issue_ctrl
//   Self-checking bench for ula_issue_ctrl. A behavioural ALU answers the
//   DUT's alu_* outputs. A scoreboard predicts each response from the request
//   alone and checks it at the handshake, and it checks that a pending
//   response holds still. Directed vectors pin latency, capacity and reset
//   behaviour with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_ula_issue_ctrl;

  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_opcode;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_operand_a;
  logic [DW-1:0] alu_operand_b;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_result;
  logic [1:0]    alu_compare;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [1:0]    rsp_cmp;
  logic [1:0]    rsp_err;
  logic [TW-1:0] rsp_tag;
  logic          busy;

  ula_issue_ctrl #(
    .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cmp(rsp_cmp), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural ALU ----------------
  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a * b;
      4'd6:    return (b == '0) ? 32'hFFFF_FFFF : a / b;
      4'd7:    return a & b;
      4'd8:    return a | b;
      4'd9:    return a << b[4:0];
      4'd10:   return a >> b[4:0];
      4'd12:   return ~a;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [1:0] cmp_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a == b) return 2'b00;
    if (a > b)  return 2'b01;
    return 2'b10;
  endfunction

  always_comb begin
    alu_result  = alu_f(alu_opcode, alu_operand_a, alu_operand_b);
    alu_compare = cmp_f(alu_operand_a, alu_operand_b);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic [1:0]    err;
    logic [1:0]    cmp;
    logic [TW-1:0] tag;
    bit            chk_res;
  } exp_t;

  exp_t exp_q[$];

  // Response predicted from the request alone.
  function automatic exp_t predict(input logic [3:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [TW-1:0] tag);
    exp_t e;
    e.tag     = tag;
    e.chk_res = 1'b1;
    e.cmp     = 2'b11;
    if (op < 4'd3 || op > 4'd12) begin
      e.res = '0;
      e.err = 2'b10;
    end else if (op == 4'd6 && b == '0) begin
      e.res = '0;
      e.err = 2'b01;
    end else begin
      e.res = alu_f(op, a, b);
      e.err = 2'b00;
      if (op == 4'd11) begin
        e.cmp     = cmp_f(a, b);
        e.chk_res = 1'b0;
      end
    end
    return e;
  endfunction

  logic          prev_valid;
  logic          prev_hs;
  logic [DW-1:0] prev_result;
  logic [1:0]    prev_cmp;
  logic [1:0]    prev_err;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_result", 64'(rsp_result), 64'(prev_result));
        check("hold_tag", 64'(rsp_tag), 64'(prev_tag));
        check("hold_err", 64'(rsp_err), 64'(prev_err));
        check("hold_cmp", 64'(rsp_cmp), 64'(prev_cmp));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got tag %0h, required no response", rsp_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_tag", 64'(rsp_tag), 64'(e.tag));
          check("sb_err", 64'(rsp_err), 64'(e.err));
          check("sb_cmp", 64'(rsp_cmp), 64'(e.cmp));
          if (e.chk_res) check("sb_result", 64'(rsp_result), 64'(e.res));
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(predict(req_opcode, req_a, req_b, req_tag));
      end
      prev_valid  <= rsp_valid;
      prev_hs     <= rsp_valid && rsp_ready;
      prev_result <= rsp_result;
      prev_cmp    <= rsp_cmp;
      prev_err    <= rsp_err;
      prev_tag    <= rsp_tag;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, output bit acc);
    logic rdy;
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = rdy;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_one(input string nm, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag, input int lat,
                         input logic [DW-1:0] r, input logic [1:0] e, input logic [1:0] c,
                         input bit chk_r);
    bit acc;
    int n;
    send(op, a, b, tag, acc);
    check({nm, "_accept"}, 64'(acc), 64'd1);
    wait_valid(n);
    check({nm, "_latency"}, 64'(n), 64'(lat));
    if (chk_r) check({nm, "_result"}, 64'(rsp_result), 64'(r));
    check({nm, "_err"}, 64'(rsp_err), 64'(e));
    check({nm, "_cmp"}, 64'(rsp_cmp), 64'(c));
    check({nm, "_tag"}, 64'(rsp_tag), 64'(tag));
    @(posedge clk);
    #1;
    check({nm, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    $display("txn %s op=%0d a=%0d b=%0d tag=%0d lat=%0d", nm, op, a, b, tag, n);
  endtask

  initial begin
    bit acc;
    int n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_cmp", 64'(rsp_cmp), 64'd3);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    check("rst_alu_a", 64'(alu_operand_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("add",     4'd3,  32'd5,   32'd7, 4'd3, 3, 32'd12, 2'b00, 2'b11, 1'b1);
    run_one("div0",    4'd6,  32'd10,  32'd0, 4'd1, 3, 32'd0,  2'b01, 2'b11, 1'b1);
    run_one("div",     4'd6,  32'd100, 32'd7, 4'd2, 3, 32'd14, 2'b00, 2'b11, 1'b1);
    run_one("cmp_gt",  4'd11, 32'd9,   32'd4, 4'd4, 3, 32'd0,  2'b00, 2'b01, 1'b0);
    run_one("cmp_lt",  4'd11, 32'd4,   32'd9, 4'd5, 3, 32'd0,  2'b00, 2'b10, 1'b0);
    run_one("cmp_eq",  4'd11, 32'd6,   32'd6, 4'd6, 3, 32'd0,  2'b00, 2'b00, 1'b0);
    run_one("illegal", 4'hF,  32'd1,   32'd2, 4'd9, 1, 32'd0,  2'b10, 2'b11, 1'b1);
    run_one("sub",     4'd4,  32'd20,  32'd5, 4'd7, 3, 32'd15, 2'b00, 2'b11, 1'b1);
    run_one("mul_wrap", 4'd5, 32'h1000_0000, 32'd16, 4'd8, 3, 32'd0, 2'b00, 2'b11, 1'b1);
    run_one("shl",     4'd9,  32'd1,   32'd4, 4'd10, 3, 32'd16, 2'b00, 2'b11, 1'b1);
    run_one("not",     4'd12, 32'd0,   32'd0, 4'd11, 3, 32'hFFFF_FFFF, 2'b00, 2'b11, 1'b1);
    run_one("and",     4'd7,  32'hF0,  32'h3C, 4'd12, 3, 32'h30, 2'b00, 2'b11, 1'b1);
    run_one("illegal0", 4'd0, 32'd3,   32'd3, 4'd13, 1, 32'd0,  2'b10, 2'b11, 1'b1);

    // Capacity: one op in flight plus four queued, then back-pressure.
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(4'd3, 32'(i), 32'd1, 4'(i), acc);
      check($sformatf("cap_accept_%0d", i), 64'(acc), (i < 5) ? 64'd1 : 64'd0);
      $display("txn cap_send tag=%0d accepted=%0d", i, acc);
    end
    check("cap_req_ready", 64'(req_ready), 64'd0);
    check("cap_busy", 64'(busy), 64'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(n);
      check($sformatf("cap_valid_%0d", k), 64'(rsp_valid), 64'd1);
      check($sformatf("cap_tag_%0d", k), 64'(rsp_tag), 64'(k));
      check($sformatf("cap_result_%0d", k), 64'(rsp_result), 64'(k + 1));
      $display("txn cap_rsp tag=%0d result=%0d", rsp_tag, rsp_result);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("cap_drained_busy", 64'(busy), 64'd0);

    // Reset asserted while an op is being driven and another is queued.
    send(4'd5, 32'd6, 32'd7, 4'd11, acc);
    send(4'd3, 32'd1, 32'd1, 4'd12, acc);
    check("rd_busy", 64'(busy), 64'd1);
    check("rd_alu_opcode", 64'(alu_opcode), 64'd5);
    check("rd_alu_a", 64'(alu_operand_a), 64'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rd_busy_now", 64'(busy), 64'd0);
    check("rd_alu_opcode_now", 64'(alu_opcode), 64'd0);
    check("rd_rsp_cmp_now", 64'(rsp_cmp), 64'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rd_after_busy", 64'(busy), 64'd0);
    check("rd_after_valid", 64'(rsp_valid), 64'd0);
    check("rd_after_ready", 64'(req_ready), 64'd1);
    $display("txn reset_mid_drive busy=%0d rsp_valid=%0d", busy, rsp_valid);
    run_one("post_rst", 4'd8, 32'h0F, 32'hF0, 4'd5, 3, 32'hFF, 2'b00, 2'b11, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
